// File: rtl/mt_maint_seq.sv
// Maintenance-mode sequencer: decodes MM/MOP/MDF writes into timed MC/BPICLK pulse trains.
// Optional loopback parity tracking and ROTLOOP check when MT_MAINT_PARITY_EN is defined.
module mt_maint_seq #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mtmrWRITE,
  input  logic       mrMM,
  input  logic [3:0] mrMOP,
  input  logic [8:0] mrMDF,
  output logic       mrMC,
  output logic       mrBPICLK,
  output logic [8:0] mrLOOP,
  output logic       mrBUSY,
  output logic       mrDONE,
  output logic       mrERR,
  output logic       mrPAR
);

  typedef enum logic [2:0] {StIdle, StLoad, StHi, StLo, StDone} state_e;

  localparam logic [7:0] PhaseMax = 8'(CLKDIV - 1);
  localparam logic [3:0] OpStep   = 4'd1;
  localparam logic [3:0] OpLd     = 4'd2;
  localparam logic [3:0] OpRot    = 4'd3;
  localparam logic [3:0] OpBpi    = 4'd4;

  state_e     r_state;
  logic [3:0] r_op;
  logic [8:0] r_sh;
  logic [8:0] r_cnt;
  logic [8:0] r_loop;
  logic [7:0] r_phase;
  logic       r_mc;
  logic       r_bpi;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  logic       w_wr_set;
  logic       w_wr_clr;
  logic       w_ready;
  logic       w_legal;
  logic       w_empty;
  logic       w_shifts;
  logic       w_rot_bad;
  logic [8:0] w_cnt_init;
  logic [8:0] w_loop_shift;

  assign w_wr_set = mtmrWRITE & mrMM;
  assign w_wr_clr = mtmrWRITE & ~mrMM;
  // DONE counts as idle so a write landing on the completion cycle is accepted.
  assign w_ready  = (r_state == StIdle) | (r_state == StDone);
  assign w_legal  = (mrMOP <= OpBpi);
  assign w_empty  = (w_cnt_init == 9'd0);
  assign w_shifts = (r_op == OpLd) | (r_op == OpRot);
  assign w_loop_shift = {r_loop[7:0], (r_op == OpLd) ? r_sh[8] : r_loop[8]};

  always_comb begin
    w_cnt_init = 9'd0;
    case (mrMOP)
      OpStep:      w_cnt_init = 9'd1;
      OpLd, OpRot: w_cnt_init = 9'd9;
      OpBpi:       w_cnt_init = mrMDF;
      default:     w_cnt_init = 9'd0;
    endcase
  end

`ifdef MT_MAINT_PARITY_EN
  logic r_par;
  logic r_par_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par     <= 1'b0;
      r_par_cap <= 1'b0;
    end else begin
      r_par <= ^r_loop;
      if (r_state == StLoad) r_par_cap <= r_par;
    end
  end

  assign w_rot_bad = (r_state == StDone) && (r_op == OpRot) && ((^r_loop) != r_par_cap);
  assign mrPAR     = r_par;
`else
  assign w_rot_bad = 1'b0;
  assign mrPAR     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= 4'd0;
      r_sh    <= 9'd0;
      r_cnt   <= 9'd0;
      r_loop  <= 9'd0;
      r_phase <= 8'd0;
      r_mc    <= 1'b0;
      r_bpi   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_clr) begin
        r_err   <= 1'b0;
        r_loop  <= 9'd0;
        r_state <= StIdle;
        r_mc    <= 1'b0;
        r_bpi   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        if (w_wr_set && !w_ready) r_err <= 1'b1;
        if (w_rot_bad) r_err <= 1'b1;
        case (r_state)
          StIdle, StDone: begin
            r_state <= StIdle;
            if (w_wr_set) begin
              if (!w_legal) begin
                r_err <= 1'b1;
              end else begin
                r_op  <= mrMOP;
                r_sh  <= mrMDF;
                r_cnt <= w_cnt_init;
                if (w_empty) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= StLoad;
                  r_busy  <= 1'b1;
                end
              end
            end
          end
          StLoad: begin
            r_state <= StHi;
            r_phase <= PhaseMax;
            r_mc    <= (r_op != OpBpi);
            r_bpi   <= (r_op == OpBpi);
          end
          StHi: begin
            if (r_phase == 8'd0) begin
              r_state <= StLo;
              r_phase <= PhaseMax;
              r_mc    <= 1'b0;
              r_bpi   <= 1'b0;
            end else begin
              r_phase <= r_phase - 8'd1;
            end
          end
          StLo: begin
            if (r_phase != 8'd0) begin
              r_phase <= r_phase - 8'd1;
            end else begin
              r_cnt <= r_cnt - 9'd1;
              if (w_shifts) begin
                r_loop <= w_loop_shift;
                r_sh   <= {r_sh[7:0], 1'b0};
              end
              if (r_cnt == 9'd1) begin
                r_state <= StDone;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= StHi;
                r_phase <= PhaseMax;
                r_mc    <= (r_op != OpBpi);
                r_bpi   <= (r_op == OpBpi);
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign mrMC     = r_mc;
  assign mrBPICLK = r_bpi;
  assign mrLOOP   = r_loop;
  assign mrBUSY   = r_busy;
  assign mrDONE   = r_done;
  assign mrERR    = r_err;

endmodule
